// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants, ALU-op and immediate-format encodings.
// Imported by decode and by the execute/memory stages that consume them.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        illegal;
  } dec_t;

  // alt selects SUB (funct3=000) or SRA (funct3=101)
  function automatic alu_op_e alu_from_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e r;
    unique case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator.
// All formats sign-extend from instr[31].
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  logic s;
  assign s = instr_i[31];

  always_comb begin
    imm_o = 32'd0;
    unique case (fmt_i)
      IMM_I: imm_o = {{20{s}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{s}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{s}}, s, instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'd0};
      IMM_J: imm_o = {{11{s}}, s, instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field decode plus the ID/EX pipeline register.
// Flush beats stall, stall beats capture/bubble.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int IWIDTH    = 32,
  parameter int PC_WIDTH  = 32,
  parameter int ALU_WIDTH = 4
) (
  input  logic                 ds_clk,
  input  logic                 ds_rst,
  input  logic [IWIDTH-1:0]    ds_i_instr,
  input  logic [PC_WIDTH-1:0]  ds_i_pc,
  input  logic                 ds_i_ce,
  input  logic                 ds_i_stall,
  input  logic                 ds_i_flush,
  output logic                 ds_o_stall,
  output logic                 ds_o_flush,
  output logic                 ds_o_ce,
  output logic [PC_WIDTH-1:0]  ds_o_pc,
  output logic [IWIDTH-1:0]    ds_o_instr,
  output logic [4:0]           ds_o_rs1_addr,
  output logic [4:0]           ds_o_rs2_addr,
  output logic [4:0]           ds_o_rd_addr,
  output logic [31:0]          ds_o_imm,
  output logic [ALU_WIDTH-1:0] ds_o_alu_op,
  output logic [6:0]           ds_o_opcode,
  output logic [2:0]           ds_o_funct3,
  output logic                 ds_o_illegal
);

  logic [31:0]         ins;
  logic [6:0]          op;
  logic [2:0]          f3;
  logic [6:0]          f7;
  imm_fmt_e            fmt;
  logic [31:0]         imm;
  dec_t                dec;
  dec_t                dec_d, dec_q;
  logic                ce_d, ce_q;
  logic [PC_WIDTH-1:0] pc_d, pc_q;
  logic [IWIDTH-1:0]   instr_d, instr_q;

  assign ins = ds_i_instr[31:0];
  assign op  = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  imm_gen u_imm_gen (
    .instr_i (ins),
    .fmt_i   (fmt),
    .imm_o   (imm)
  );

  always_comb begin
    fmt         = IMM_I;
    dec.rs1     = ins[19:15];
    dec.rs2     = 5'd0;
    dec.rd      = ins[11:7];
    dec.alu     = ALU_ADD;
    dec.opcode  = op;
    dec.funct3  = f3;
    dec.illegal = 1'b0;
    unique case (op)
      OPC_LUI, OPC_AUIPC: begin
        fmt     = IMM_U;
        dec.rs1 = 5'd0;
      end
      OPC_JAL: begin
        fmt     = IMM_J;
        dec.rs1 = 5'd0;
      end
      OPC_JALR, OPC_LOAD, OPC_SYSTEM: fmt = IMM_I;
      OPC_BRANCH: begin
        fmt     = IMM_B;
        dec.rs2 = ins[24:20];
        dec.rd  = 5'd0;
        dec.alu = ALU_SUB;
      end
      OPC_STORE: begin
        fmt     = IMM_S;
        dec.rs2 = ins[24:20];
        dec.rd  = 5'd0;
      end
      OPC_OPIMM: begin
        dec.alu = alu_from_f3(f3, (f3 == 3'b101) && ins[30]);
      end
      OPC_OP: begin
        fmt         = IMM_NONE;
        dec.rs2     = ins[24:20];
        dec.alu     = alu_from_f3(f3, ins[30]);
        dec.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_FENCE: dec.rd = 5'd0;
      default:   dec.illegal = 1'b1;
    endcase
    // Quiet the register fields so a trapping op has no side effects
    if (dec.illegal) begin
      dec.rs1 = 5'd0;
      dec.rs2 = 5'd0;
      dec.rd  = 5'd0;
      dec.alu = ALU_ADD;
    end
  end

  always_comb begin
    ce_d    = ce_q;
    dec_d   = dec_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (ds_i_flush) begin
      ce_d = 1'b0;
    end else if (!ds_i_stall) begin
      ce_d = ds_i_ce;
      if (ds_i_ce) begin
        dec_d     = dec;
        dec_d.imm = imm;
        pc_d      = ds_i_pc;
        instr_d   = ds_i_instr;
      end
    end
  end

  always_ff @(posedge ds_clk or negedge ds_rst) begin
    if (!ds_rst) begin
      ce_q    <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      ce_q    <= ce_d;
      dec_q   <= dec_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign ds_o_stall    = ds_i_stall;
  assign ds_o_flush    = ds_i_flush;
  assign ds_o_ce       = ce_q;
  assign ds_o_pc       = pc_q;
  assign ds_o_instr    = instr_q;
  assign ds_o_rs1_addr = dec_q.rs1;
  assign ds_o_rs2_addr = dec_q.rs2;
  assign ds_o_rd_addr  = dec_q.rd;
  assign ds_o_imm      = dec_q.imm;
  assign ds_o_alu_op   = ALU_WIDTH'(dec_q.alu);
  assign ds_o_opcode   = dec_q.opcode;
  assign ds_o_funct3   = dec_q.funct3;
  assign ds_o_illegal  = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage.
// Hand-computed RV32I encodings and expected decode fields.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ce, stall, flush;
  logic        o_stall, o_flush, o_ce, o_ill;
  logic [31:0] o_pc, o_instr, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [3:0]  o_alu;
  logic [6:0]  o_opc;
  logic [2:0]  o_f3;

  int total = 0;
  int bad   = 0;

  decode_stage dut (
    .ds_clk        (clk),
    .ds_rst        (rst_n),
    .ds_i_instr    (instr),
    .ds_i_pc       (pc),
    .ds_i_ce       (ce),
    .ds_i_stall    (stall),
    .ds_i_flush    (flush),
    .ds_o_stall    (o_stall),
    .ds_o_flush    (o_flush),
    .ds_o_ce       (o_ce),
    .ds_o_pc       (o_pc),
    .ds_o_instr    (o_instr),
    .ds_o_rs1_addr (o_rs1),
    .ds_o_rs2_addr (o_rs2),
    .ds_o_rd_addr  (o_rd),
    .ds_o_imm      (o_imm),
    .ds_o_alu_op   (o_alu),
    .ds_o_opcode   (o_opc),
    .ds_o_funct3   (o_f3),
    .ds_o_illegal  (o_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive, clock once, sample 1ns after the edge
  task automatic cyc(input logic [31:0] i, input logic [31:0] p,
                     input logic c, input logic s, input logic f);
    instr = i; pc = p; ce = c; stall = s; flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input string t, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm, input logic [3:0] alu,
                     input logic ill);
    chk({t, ".ce"},  32'(o_ce), 32'd1);
    chk({t, ".rd"},  32'(o_rd), 32'(rd));
    chk({t, ".rs1"}, 32'(o_rs1), 32'(rs1));
    chk({t, ".rs2"}, 32'(o_rs2), 32'(rs2));
    chk({t, ".imm"}, o_imm, imm);
    chk({t, ".alu"}, 32'(o_alu), 32'(alu));
    chk({t, ".ill"}, 32'(o_ill), 32'(ill));
  endtask

  logic [31:0] h_instr, h_imm;
  logic [4:0]  h_rd;

  initial begin
    rst_n = 1'b0;
    instr = 32'h0; pc = 32'h0;
    ce = 1'b0; stall = 1'b0; flush = 1'b0;
    #12;
    chk("rst.ce",  32'(o_ce), 32'd0);
    chk("rst.alu", 32'(o_alu), 32'd0);
    chk("rst.ill", 32'(o_ill), 32'd0);
    chk("rst.imm", o_imm, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    cyc(32'h00500093, 32'h0, 1, 0, 0);
    dec("addi", 5'd1, 5'd0, 5'd0, 32'h5, 4'd0, 1'b0);
    chk("addi.pc", o_pc, 32'h0);
    chk("addi.opc", 32'(o_opc), 32'h13);

    cyc(32'hFE000EE3, 32'h4, 1, 0, 0);
    dec("beq", 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 4'd1, 1'b0);
    chk("beq.f3", 32'(o_f3), 32'd0);
    chk("beq.pc", o_pc, 32'h4);

    cyc(32'h12345537, 32'h8, 1, 0, 0);
    dec("lui", 5'd10, 5'd0, 5'd0, 32'h12345000, 4'd0, 1'b0);

    cyc(32'hFF9FF0EF, 32'hC, 1, 0, 0);
    dec("jal", 5'd1, 5'd0, 5'd0, 32'hFFFFFFF8, 4'd0, 1'b0);

    cyc(32'h00512423, 32'h10, 1, 0, 0);
    dec("sw", 5'd0, 5'd2, 5'd5, 32'h8, 4'd0, 1'b0);
    chk("sw.f3", 32'(o_f3), 32'd2);

    cyc(32'h40335293, 32'h14, 1, 0, 0);
    dec("srai", 5'd5, 5'd6, 5'd0, 32'h403, 4'd7, 1'b0);

    cyc(32'h02208133, 32'h18, 1, 0, 0);
    dec("mul", 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 1'b1);

    cyc(32'h402081B3, 32'h1C, 1, 0, 0);
    dec("sub", 5'd3, 5'd1, 5'd2, 32'h0, 4'd1, 1'b0);
    h_instr = 32'h402081B3;
    h_imm   = 32'h0;
    h_rd    = 5'd3;

    for (int k = 0; k < 3; k++) begin
      cyc(32'h00500093 + 32'(k << 7), 32'h100 + 32'(k), 1, 1, 0);
      chk("stall.o_stall", 32'(o_stall), 32'd1);
      chk("stall.ce", 32'(o_ce), 32'd1);
      chk("stall.instr", o_instr, h_instr);
      chk("stall.rd", 32'(o_rd), 32'(h_rd));
      chk("stall.pc", o_pc, 32'h1C);
      chk("stall.alu", 32'(o_alu), 32'd1);
    end

    instr = 32'h00500093; ce = 1'b1; stall = 1'b1; flush = 1'b1;
    #1;
    chk("flush.o_flush", 32'(o_flush), 32'd1);
    @(posedge clk); #1;
    chk("flush.ce", 32'(o_ce), 32'd0);

    cyc(32'h00500093, 32'h20, 0, 0, 0);
    chk("bubble.ce", 32'(o_ce), 32'd0);
    chk("bubble.o_stall", 32'(o_stall), 32'd0);

    cyc(32'h00000000, 32'h24, 1, 0, 0);
    dec("zero", 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 1'b1);

    cyc(32'h00500093, 32'h28, 1, 0, 0);
    chk("pre_rst.ce", 32'(o_ce), 32'd1);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.ce",  32'(o_ce), 32'd0);
    chk("arst.pc",  o_pc, 32'd0);
    chk("arst.rd",  32'(o_rd), 32'd0);
    chk("arst.imm", o_imm, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    cyc(32'h00500093, 32'h30, 1, 0, 0);
    dec("post_rst", 5'd1, 5'd0, 5'd0, 32'h5, 4'd0, 1'b0);
    chk("post_rst.pc", o_pc, 32'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
